neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 104 ++++++++++
 tb/tb_neuron_mac.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: pipelined fixed-point multiply-accumulate neuron with saturating sum,
// registered weight address and bias add on vector completion.
module neuron_mac #(
  parameter int numWeight    = 4,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [dataWidth-1:0]    in_data,
  output logic        [addressWidth-1:0] radd,
  input  logic signed [dataWidth-1:0]    wout,
  input  logic signed [dataWidth-1:0]    bias,
  output logic signed [dataWidth-1:0]    out_data,
  output logic                           out_valid,
  output logic                           out_sat
);
  localparam int DW = dataWidth;
  localparam int PW = 2 * dataWidth;

  // returns {overflow, clamped value}
  function automatic logic [DW:0] sat(input logic signed [PW-1:0] x);
    logic ovf;
    ovf = !((&x[PW-1:DW-1]) || !(|x[PW-1:DW-1]));
    return ovf ? {1'b1, x[PW-1], {(DW-1){~x[PW-1]}}} : {1'b0, x[DW-1:0]};
  endfunction

  logic [addressWidth-1:0] radd_q, radd_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic signed [DW-1:0]    b1_q, b1_d, b2_q, b2_d;
  logic signed [DW-1:0]    acc_q, acc_d;
  logic                    fin_q, fin_d, sticky_q, sticky_d;
  logic signed [DW-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic                    first0, last0, s_scl, s_add, s_out;
  logic signed [PW-1:0]    shifted, acc_ext, scl_ext, b2_ext;
  logic signed [DW-1:0]    scaled, added, fin_val;

  always_comb begin
    first0      = radd_q == '0;
    last0       = radd_q == addressWidth'(numWeight - 1);
    radd_d      = in_valid ? (last0 ? '0 : radd_q + addressWidth'(1)) : radd_q;
    prod_d      = PW'(in_data) * PW'(wout);
    v1_d        = in_valid;
    f1_d        = in_valid & first0;
    l1_d        = in_valid & last0;
    b1_d        = bias;
    shifted     = prod_q >>> fracBits;
    {s_scl, scaled} = sat(shifted);
    acc_ext     = acc_q;
    scl_ext     = scaled;
    {s_add, added} = sat(acc_ext + scl_ext);
    acc_d       = v1_q ? (f1_q ? scaled : added) : acc_q;
    sticky_d    = v1_q ? ((f1_q ? 1'b0 : (sticky_q | s_add)) | s_scl) : sticky_q;
    fin_d       = v1_q & l1_q;
    // bias travels with the last sample so the next vector may change it freely
    b2_d        = (v1_q & l1_q) ? b1_q : b2_q;
    b2_ext      = b2_q;
    {s_out, fin_val} = sat(acc_ext + b2_ext);
    out_data_d  = fin_q ? fin_val : out_data_q;
    out_valid_d = fin_q;
    out_sat_d   = fin_q ? (sticky_q | s_out) : out_sat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radd_q      <= '0;
      prod_q      <= '0;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      b1_q        <= '0;
      b2_q        <= '0;
      acc_q       <= '0;
      fin_q       <= 1'b0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      radd_q      <= radd_d;
      prod_q      <= prod_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      l1_q        <= l1_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      acc_q       <= acc_d;
      fin_q       <= fin_d;
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign radd      = radd_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed scoreboard bench for neuron_mac against
// an integer reference model of the neuron arithmetic.
module tb_neuron_mac;
  localparam int NW = 4, AW = 10, DW = 16, FB = 8;
  typedef logic signed [15:0] vec_t [NW];
  typedef struct { logic signed [15:0] d; logic s; int c; } exp_t;

  logic clk = 0, rst_n = 0, in_valid = 0;
  logic signed [15:0] in_data = 0, bias = 0, wout, out_data;
  logic [AW-1:0] radd;
  logic out_valid, out_sat;
  logic signed [15:0] wmem [NW];

  exp_t q[$];
  exp_t e;
  int cyc = 0, n_cmp = 0, n_bad = 0, idx = 0;
  longint acc;
  bit vsat, seen = 0;
  logic signed [15:0] last_d;

  vec_t w_one = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
  vec_t x_inc = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  vec_t w_neg = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
  vec_t x_max = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

  neuron_mac #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .radd(radd),
    .wout(wout), .bias(bias), .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat)
  );

  assign wout = wmem[int'(radd) % NW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint clamp(input longint v, inout bit s);
    if (v > 32767) begin s = 1; return 32767; end
    if (v < -32768) begin s = 1; return -32768; end
    return v;
  endfunction

  function automatic logic signed [15:0] rnd();
    return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 0; end
  endtask

  // gap < 0 selects a random gap of 0..2 idle cycles before each sample
  task automatic vec(input vec_t xs, input vec_t ws, input logic signed [15:0] b,
                     input int gap, input int n);
    longint p, f;
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(negedge clk); in_valid = 0;
        chk("radd_hold", radd, idx);
      end
      @(negedge clk);
      if (i == 0) begin wmem = ws; bias = b; end
      chk("radd", radd, idx);
      in_valid = 1; in_data = xs[i];
      p = (longint'(xs[i]) * longint'(wmem[idx])) >>> FB;
      if (idx == 0) begin vsat = 0; acc = clamp(p, vsat); end
      else acc = clamp(acc + clamp(p, vsat), vsat);
      if (idx == NW - 1) begin
        f = clamp(acc + longint'(bias), vsat);
        q.push_back('{16'(f), vsat, cyc + 3});
      end
      idx = (idx + 1) % NW;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sat", out_sat, e.s);
        chk("latency", cyc, e.c);
      end
      last_d = out_data;
      seen = 1;
    end else if (seen) chk("out_hold", out_data, last_d);
  end

  initial begin
    vec_t xr, wr;
    int t;
    for (int i = 0; i < NW; i++) wmem[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_radd", radd, 0);
    rst_n = 1;
    idle(2);
    vec(x_inc, w_one, 16'h0080, 0, NW);
    idle(5);
    vec(x_inc, w_neg, 16'h0000, 0, NW);
    idle(5);
    vec(x_max, x_max, 16'h0000, 0, NW);
    vec(x_inc, w_one, 16'h0080, 0, NW);
    idle(5);
    vec(x_inc, w_one, 16'h0080, 0, NW);
    vec(w_one, w_neg, 16'h0000, 0, NW);
    idle(5);
    vec(x_inc, w_one, 16'h0080, 2, NW);
    idle(6);
    vec(x_inc, w_one, 16'h0080, 0, 2);
    @(negedge clk); in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_sat", out_sat, 0);
    chk("mid_rst_radd", radd, 0);
    idx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_radd", radd, 0);
    vec(x_inc, w_one, 16'h0080, 0, NW);
    idle(4);
    for (int v = 0; v < 30; v++) begin
      for (int i = 0; i < NW; i++) begin xr[i] = rnd(); wr[i] = rnd(); end
      vec(xr, wr, rnd(), (v % 3 == 0) ? -1 : 0, NW);
    end
    idle(1);
    t = 0;
    while (q.size() > 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", q.size(), 0);
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
